// File: rtl/fec_viterbi_decoder_if.sv
// Serial coded-bit input and decoded-bit output handshakes of the Viterbi decoder.
interface fec_viterbi_decoder_if;
    logic in_valid;
    logic in_data;
    logic in_ready;
    logic out_valid;
    logic out_data;
    logic out_ready;

    // Upstream/downstream side: drives coded bits and accepts decoded bits.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Decoder side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fec_viterbi_decoder.sv
// Block Viterbi decoder for a tail-biting rate-1/2 K=7 convolutional code.
// Receives 2*N_BITS coded bits (X,Y per info bit), runs one 64-state ACS step
// per info bit, picks the best end state, traces back through the stored
// decisions and streams the N_BITS decoded bits out, bit 0 first.
module fec_viterbi_decoder #(
    parameter int         N_BITS = 96,
    parameter logic [6:0] G1     = 7'b1111001,
    parameter logic [6:0] G2     = 7'b1011011
) (
    input  logic                   clock_50,
    input  logic                   reset,
    fec_viterbi_decoder_if.slave   bus
);
    localparam int NS = 64;

    typedef enum logic [2:0] {IDLE, RECV, SELECT, TRACE, OUTPUT} state_t;

    state_t               state, state_nxt;
    logic                 x_have, x_reg;
    logic [6:0]           step, k, idx;
    logic [5:0]           sel_cnt, best_state, tb_s;
    logic [7:0]           best_metric;
    logic                 trace_seed;
    logic [NS-1:0][7:0]   pm, pm_nxt;
    logic [NS-1:0]        dec;
    logic [NS-1:0]        surv [N_BITS];
    logic [N_BITS-1:0]    decoded;
    logic                 in_fire, y_fire, out_fire;

    assign bus.in_ready  = (state == IDLE) || (state == RECV);
    assign bus.out_valid = (state == OUTPUT);
    assign bus.out_data  = (state == OUTPUT) ? decoded[idx] : 1'b0;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign y_fire   = in_fire && x_have;
    assign out_fire = bus.out_valid && bus.out_ready;

    // Add-compare-select for every next state; expected branch bits are
    // elaboration-time constants, so each lane is two adders and a compare.
    for (genvar n = 0; n < NS; n++) begin : g_acs
        localparam logic [5:0] NXT = 6'(n);
        localparam logic [5:0] P0  = {NXT[4:0], 1'b0};
        localparam logic [5:0] P1  = {NXT[4:0], 1'b1};
        localparam logic EX0 = ^({NXT[5], P0} & G1);
        localparam logic EY0 = ^({NXT[5], P0} & G2);
        localparam logic EX1 = ^({NXT[5], P1} & G1);
        localparam logic EY1 = ^({NXT[5], P1} & G2);
        logic [1:0] bm0, bm1;
        logic [7:0] m0, m1;
        assign bm0 = {1'b0, x_reg ^ EX0} + {1'b0, bus.in_data ^ EY0};
        assign bm1 = {1'b0, x_reg ^ EX1} + {1'b0, bus.in_data ^ EY1};
        assign m0  = pm[P0] + {6'd0, bm0};
        assign m1  = pm[P1] + {6'd0, bm1};
        // Ties resolve to the even predecessor.
        assign dec[n]    = (m1 < m0);
        assign pm_nxt[n] = dec[n] ? m1 : m0;
    end

    // State register.
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_fire) state_nxt = RECV;
            RECV:    if (y_fire && step == 7'(N_BITS - 1)) state_nxt = SELECT;
            SELECT:  if (sel_cnt == 6'd63) state_nxt = TRACE;
            TRACE:   if (!trace_seed && k == 7'd0) state_nxt = OUTPUT;
            OUTPUT:  if (out_fire && idx == 7'(N_BITS - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Survivor decisions; every row is written before traceback reads it.
    always_ff @(posedge clock_50) begin
        if (y_fire) surv[step] <= dec;
    end

    // Receive, metric update, best-state scan, traceback and output index.
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            x_have      <= 1'b0;
            x_reg       <= 1'b0;
            step        <= '0;
            pm          <= '0;
            sel_cnt     <= '0;
            best_state  <= '0;
            best_metric <= '0;
            tb_s        <= '0;
            k           <= '0;
            trace_seed  <= 1'b0;
            idx         <= '0;
            decoded     <= '0;
        end else begin
            if (in_fire) begin
                if (!x_have) begin
                    x_reg  <= bus.in_data;
                    x_have <= 1'b1;
                end else begin
                    x_have <= 1'b0;
                    pm     <= pm_nxt;
                    step   <= step + 7'd1;
                end
            end
            unique case (state)
                IDLE: begin
                    // Unknown start state: every metric begins equal.
                    pm      <= '0;
                    step    <= '0;
                    sel_cnt <= '0;
                    idx     <= '0;
                end
                SELECT: begin
                    if (sel_cnt == 6'd0 || pm[sel_cnt] < best_metric) begin
                        best_metric <= pm[sel_cnt];
                        best_state  <= sel_cnt;
                    end
                    sel_cnt <= sel_cnt + 6'd1;
                    if (sel_cnt == 6'd63) trace_seed <= 1'b1;
                end
                TRACE: begin
                    // First cycle seeds traceback from the scan winner.
                    if (trace_seed) begin
                        tb_s       <= best_state;
                        k          <= 7'(N_BITS - 1);
                        trace_seed <= 1'b0;
                    end else begin
                        decoded[k] <= tb_s[5];
                        tb_s       <= {tb_s[4:0], surv[k][tb_s]};
                        k          <= k - 7'd1;
                    end
                end
                OUTPUT: begin
                    if (out_fire) idx <= (idx == 7'(N_BITS - 1)) ? 7'd0 : idx + 7'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fec_viterbi_decoder.sv
// Self-checking bench: encodes info blocks with a tail-biting encoder model,
// feeds them through the decoder and compares decoded bits, latency and
// handshake behaviour against expectations derived from the encoder model.
module tb_fec_viterbi_decoder;
    localparam int         N   = 96;
    localparam logic [6:0] G1  = 7'b1111001;
    localparam logic [6:0] G2  = 7'b1011011;
    localparam int         LAT = 64 + N + 1;

    logic clock_50 = 1'b0;
    logic reset    = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    always #5 clock_50 = ~clock_50;

    fec_viterbi_decoder_if bif();

    fec_viterbi_decoder #(.N_BITS(N), .G1(G1), .G2(G2)) dut (
        .clock_50 (clock_50),
        .reset    (reset),
        .bus      (bif)
    );

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Tail-biting encoder: start state holds the last six info bits.
    function automatic logic [2*N-1:0] encode(input logic [N-1:0] info);
        logic [5:0]     s;
        logic [6:0]     r;
        logic [2*N-1:0] c;
        for (int i = 0; i < 6; i++) s[5-i] = info[N-1-i];
        c = '0;
        for (int j = 0; j < N; j++) begin
            r          = {info[j], s};
            c[2*j]     = ^(r & G1);
            c[2*j+1]   = ^(r & G2);
            s          = {info[j], s[5:1]};
        end
        return c;
    endfunction

    // gap_mode: 0 contiguous, 1 valid every other cycle, 2 random gaps.
    task automatic send_bits(input string tag, input logic [2*N-1:0] c, input int nbits, input int gap_mode);
        int i  = 0;
        int ph = 0;
        bit v;
        bit rdy_ok = 1'b1;
        while (i < nbits) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (ph % 2 == 0);
                default: v = ($urandom_range(0, 9) < 7);
            endcase
            ph++;
            bif.in_valid = v;
            bif.in_data  = v ? c[i] : 1'($urandom_range(0, 1));
            if (v && !bif.in_ready) rdy_ok = 1'b0;
            @(posedge clock_50); #1;
            if (v) i++;
        end
        bif.in_valid = 1'b0;
        bif.in_data  = 1'b0;
        chk({tag, " in_ready_recv"}, N'(rdy_ok), N'(1));
    endtask

    // rdy_mode: 0 always ready, 1 ready one cycle in three, 2 random.
    task automatic run_block(input string tag, input logic [N-1:0] info, input int err,
                             input int gap_mode, input int rdy_mode);
        logic [2*N-1:0] c;
        logic [N-1:0]   got;
        int             lat, idx, cyc, unstable;
        bit             busy_ok, proto_ok, r, held_v, held;
        c = encode(info);
        if (err >= 0) c[err] = ~c[err];
        send_bits(tag, c, 2*N, gap_mode);
        lat     = 0;
        busy_ok = 1'b1;
        while (!bif.out_valid && lat < 400) begin
            @(posedge clock_50); #1;
            lat++;
            if (bif.in_ready) busy_ok = 1'b0;
        end
        chk({tag, " latency"}, N'(lat), N'(LAT));
        chk({tag, " in_ready_busy"}, N'(busy_ok), N'(1));
        if (!bif.out_valid) return;
        got = '0; idx = 0; cyc = 0; unstable = 0;
        proto_ok = 1'b1; held_v = 1'b0; held = 1'b0;
        while (idx < N && cyc < 2000) begin
            case (rdy_mode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 2);
                default: r = 1'($urandom_range(0, 1));
            endcase
            bif.out_ready = r;
            if (!bif.out_valid || bif.in_ready) proto_ok = 1'b0;
            if (held_v && bif.out_data !== held) unstable++;
            if (r) begin
                got[idx] = bif.out_data;
                idx++;
                held_v = 1'b0;
            end else begin
                held   = bif.out_data;
                held_v = 1'b1;
            end
            @(posedge clock_50); #1;
            cyc++;
        end
        bif.out_ready = 1'b0;
        chk({tag, " data"}, got, info);
        chk({tag, " out_protocol"}, N'(proto_ok), N'(1));
        chk({tag, " out_stable"}, N'(unstable), N'(0));
        chk({tag, " out_valid_drop"}, N'(bif.out_valid), N'(0));
        chk({tag, " in_ready_idle"}, N'(bif.in_ready), N'(1));
    endtask

    task automatic pulse_reset(input string tag);
        #3 reset = 1'b0;
        #1;
        chk({tag, " rst_out_valid"}, N'(bif.out_valid), N'(0));
        chk({tag, " rst_in_ready"}, N'(bif.in_ready), N'(1));
        chk({tag, " rst_out_data"}, N'(bif.out_data), N'(0));
        @(negedge clock_50);
        @(negedge clock_50);
        reset = 1'b1;
        @(posedge clock_50); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] pat;
        logic [N-1:0] rnd;
        bif.in_valid  = 1'b0;
        bif.in_data   = 1'b0;
        bif.out_ready = 1'b0;
        pat = 96'hA5C3_0F1E_7788_9ABC_DEF0_1234;

        #23;
        chk("reset out_valid", N'(bif.out_valid), N'(0));
        chk("reset out_data",  N'(bif.out_data),  N'(0));
        chk("reset in_ready",  N'(bif.in_ready),  N'(1));
        @(negedge clock_50);
        reset = 1'b1;
        @(posedge clock_50); #1;

        run_block("zeros",      '0,  -1, 0, 0);
        run_block("pattern",    pat, -1, 0, 0);
        run_block("pattern_e50", pat, 50, 0, 0);
        run_block("toggle_in",  pat, -1, 1, 0);
        run_block("ready_1of3", pat, -1, 0, 1);

        for (int b = 0; b < 3; b++) begin
            rnd = {$urandom, $urandom, $urandom};
            run_block("random", rnd, (b == 2) ? int'($urandom_range(40, 150)) : -1, 2, 2);
        end

        // Abort mid-receive: no bits of the partial block may survive.
        rnd = {$urandom, $urandom, $urandom} | 96'h1;
        send_bits("abort_recv", encode(rnd), 100, 0);
        pulse_reset("abort_recv");
        run_block("after_abort", '0, -1, 0, 0);

        // Abort during the scan/traceback of a complete block.
        rnd = {$urandom, $urandom, $urandom} | 96'h1;
        send_bits("abort_sel", encode(rnd), 2*N, 0);
        repeat (30) @(posedge clock_50);
        #1;
        pulse_reset("abort_sel");
        run_block("after_abort_sel", pat, -1, 2, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
